cpu_step_ctrl: RTL and testbench

//   Parametrised CPU clock-enable generator for the board build of the multi-cycle CPU.

---
 rtl/cpu_step_ctrl_if.sv | 41 ++++
 rtl/cpu_step_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_ctrl_if.sv
// Control/status bundle between the board step logic and cpu_step_ctrl.
// The step_cnt signal exists only when STEP_COUNTER_EN is defined.
interface cpu_step_ctrl_if #(
  parameter int DIV_W   = 24,
  parameter int BURST_W = 8
);

  logic [1:0]         mode;
  logic [DIV_W-1:0]   div_val;
  logic [BURST_W-1:0] burst_len;
  logic               btn;
  logic               halt;
  logic               cpu_en;
  logic               busy;
`ifdef STEP_COUNTER_EN
  logic [31:0]        step_cnt;
`endif

`ifdef STEP_COUNTER_EN
  modport master (
    output mode, div_val, burst_len, btn, halt,
    input  cpu_en, busy, step_cnt
  );

  modport slave (
    input  mode, div_val, burst_len, btn, halt,
    output cpu_en, busy, step_cnt
  );
`else
  modport master (
    output mode, div_val, burst_len, btn, halt,
    input  cpu_en, busy
  );

  modport slave (
    input  mode, div_val, burst_len, btn, halt,
    output cpu_en, busy
  );
`endif

endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: free-run, divided, single-step and burst modes.
// Define STEP_COUNTER_EN to add the 32-bit step_cnt strobe counter.
module cpu_step_ctrl #(
  parameter int DIV_W      = 24,
  parameter int BURST_W    = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_step_ctrl_if.slave bus
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_DIV   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DIV   = 2'b10,
    BURST = 2'b11
  } state_t;

  state_t             state, state_n;
  logic               btn_s1, btn_s2;
  logic [DEB_W-1:0]   deb_cnt;
  logic               btn_db, btn_db_d;
  logic               press;
  logic [1:0]         mode_q;
  logic               stop;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [DIV_W-1:0]   div_lim, div_lim_n;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_n;
  logic               cpu_en_q, cpu_en_n;
  logic               busy_q, busy_n;

  // The debounced level only moves after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_s1   <= bus.btn;
      btn_s2   <= btn_s1;
      btn_db_d <= btn_db;
      if (btn_s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        btn_db  <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_d;
  assign stop  = bus.halt | (bus.mode != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      div_cnt   <= '0;
      div_lim   <= '0;
      burst_cnt <= '0;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= bus.mode;
      div_cnt   <= div_cnt_n;
      div_lim   <= div_lim_n;
      burst_cnt <= burst_cnt_n;
      cpu_en_q  <= cpu_en_n;
      busy_q    <= busy_n;
    end
  end

  // A mode change behaves exactly like a one-cycle halt, so a press in that cycle is lost.
  always_comb begin
    state_n     = state;
    div_cnt_n   = div_cnt;
    div_lim_n   = div_lim;
    burst_cnt_n = burst_cnt;
    cpu_en_n    = 1'b0;
    busy_n      = 1'b0;
    if (stop) begin
      state_n     = IDLE;
      div_cnt_n   = '0;
      burst_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          case (bus.mode)
            MODE_RUN: begin
              state_n  = RUN;
              cpu_en_n = 1'b1;
            end
            MODE_DIV: begin
              state_n   = DIV;
              div_cnt_n = '0;
              div_lim_n = bus.div_val;
              cpu_en_n  = (bus.div_val == '0);
            end
            MODE_STEP: begin
              cpu_en_n = press;
            end
            MODE_BURST: begin
              if (press && (bus.burst_len != '0)) begin
                state_n     = BURST;
                burst_cnt_n = bus.burst_len - BURST_W'(1);
                cpu_en_n    = 1'b1;
                busy_n      = 1'b1;
              end
            end
            default: ;
          endcase
        end
        RUN: begin
          cpu_en_n = 1'b1;
        end
        // The strobe is aligned with the cycle in which the counter equals the limit.
        DIV: begin
          if (div_cnt == div_lim) begin
            div_cnt_n = '0;
            div_lim_n = bus.div_val;
            cpu_en_n  = (bus.div_val == '0);
          end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
            cpu_en_n  = (div_cnt_n == div_lim);
          end
        end
        BURST: begin
          if (burst_cnt == '0) begin
            state_n = IDLE;
          end else begin
            burst_cnt_n = burst_cnt - BURST_W'(1);
            cpu_en_n    = 1'b1;
            busy_n      = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_en = cpu_en_q;
  assign bus.busy   = busy_q;

`ifdef STEP_COUNTER_EN
  logic [31:0] step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (cpu_en_q) begin
      step_cnt <= step_cnt + 32'd1;
    end
  end

  assign bus.step_cnt = step_cnt;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with DEB_CYCLES=4; step_cnt checks need STEP_COUNTER_EN.
module tb_cpu_step_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_pass;
  int   n_total;

  typedef struct packed {
    int           cyc;
    logic         chk_en;
    logic         en;
    logic         busy;
    logic         chk_cnt;
    logic [31:0]  cnt;
    logic [95:0]  name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cpu_step_ctrl_if #(.DIV_W(24), .BURST_W(8)) bus ();

  cpu_step_ctrl #(
    .DIV_W(24),
    .BURST_W(8),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [23:0] dv,
                               input logic [7:0] bl, input logic h);
    bus.mode      = m;
    bus.div_val   = dv;
    bus.burst_len = bl;
    bus.halt      = h;
  endtask

  task automatic press_btn(input int hold);
    bus.btn = 1'b1;
    tick(hold);
    bus.btn = 1'b0;
  endtask

  task automatic push_sorted(input exp_t e);
    int idx;
    idx = exp_q.size();
    while (idx > 0 && exp_q[idx-1].cyc > e.cyc) idx--;
    exp_q.insert(idx, e);
  endtask

  task automatic expect_at(input int c, input logic en, input logic bz, input logic [95:0] nm);
    exp_t e;
    e.cyc     = c;
    e.chk_en  = 1'b1;
    e.en      = en;
    e.busy    = bz;
    e.chk_cnt = 1'b0;
    e.cnt     = 32'd0;
    e.name    = nm;
    push_sorted(e);
  endtask

  task automatic expect_window(input int c0, input int n, input logic en, input logic bz,
                               input logic [95:0] nm);
    for (int i = 0; i < n; i++) expect_at(c0 + i, en, bz, nm);
  endtask

  task automatic expect_cnt(input int c, input logic [31:0] v, input logic [95:0] nm);
`ifdef STEP_COUNTER_EN
    exp_t e;
    e.cyc     = c;
    e.chk_en  = 1'b0;
    e.en      = 1'b0;
    e.busy    = 1'b0;
    e.chk_cnt = 1'b1;
    e.cnt     = v;
    e.name    = nm;
    push_sorted(e);
`else
    if (c < 0 && v != 32'd0 && nm != '0) $display("[TB] step_cnt not built");
`endif
  endtask

  task automatic checkOutput(input logic [95:0] nm, input string fld,
                             input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %0s.%0s cycle %0d: got %0h, required %0h", nm, fld, cyc, act, req);
  endtask

  // Monitor: pops every expectation due in the current cycle and compares it.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc) begin
        n_total++;
        $display("[TB] FAIL %0s.stale cycle %0d: expectation for cycle %0d never sampled",
                 mon_e.name, cyc, mon_e.cyc);
      end else begin
        if (mon_e.chk_en) begin
          checkOutput(mon_e.name, "cpu_en", {31'd0, bus.cpu_en}, {31'd0, mon_e.en});
          checkOutput(mon_e.name, "busy", {31'd0, bus.busy}, {31'd0, mon_e.busy});
        end
`ifdef STEP_COUNTER_EN
        if (mon_e.chk_cnt) checkOutput(mon_e.name, "step_cnt", bus.step_cnt, mon_e.cnt);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, h, a, rb, c3, d, e, f, g, k, m, guard;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.btn = 1'b0;
    applyStimulus(2'b00, 24'd0, 8'd0, 1'b0);

    // Reset, then free run with a halt pulse in the middle.
    tick(3);
    c = cyc;
    expect_window(c, 3, 1'b0, 1'b0, "reset");
    expect_cnt(c, 32'd0, "reset");
    tick(2);
    rst_n = 1'b1;
    expect_window(c + 3, 8, 1'b1, 1'b0, "run");
    wait_until(c + 11);
    h = cyc;
    expect_at(h, 1'b1, 1'b0, "halt_edge");
    expect_window(h + 1, 5, 1'b0, 1'b0, "halted");
    expect_window(h + 6, 5, 1'b1, 1'b0, "restart");
    applyStimulus(2'b00, 24'd0, 8'd0, 1'b1);
    tick(5);
    applyStimulus(2'b00, 24'd0, 8'd0, 1'b0);
    wait_until(h + 11);

    // Divided run: period 4, then div_val=0 taking effect at the next wrap.
    a = cyc;
    expect_at(a, 1'b1, 1'b0, "div_entry");
    for (int o = 1; o <= 16; o++)
      expect_at(a + o, (o == 5 || o == 9 || o == 13), 1'b0, "div3");
    expect_window(a + 17, 8, 1'b1, 1'b0, "div0");
    applyStimulus(2'b01, 24'd3, 8'd0, 1'b0);
    wait_until(a + 15);
    applyStimulus(2'b01, 24'd0, 8'd0, 1'b0);
    wait_until(a + 25);

    // Async reset while the divider is strobing every cycle.
    rb = cyc;
    expect_window(rb, 6, 1'b0, 1'b0, "reset2");
    expect_cnt(rb, 32'd0, "reset2");
    rst_n = 1'b0;
    applyStimulus(2'b10, 24'd0, 8'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    wait_until(rb + 6);

    // Single step: a 2-cycle glitch is filtered, a long hold gives one strobe.
    c3 = cyc;
    expect_window(c3, 12, 1'b0, 1'b0, "glitch");
    bus.btn = 1'b1;
    tick(2);
    bus.btn = 1'b0;
    wait_until(c3 + 12);
    d = cyc;
    expect_window(d, 7, 1'b0, 1'b0, "step_wait");
    expect_at(d + 7, 1'b1, 1'b0, "step");
    expect_window(d + 8, 23, 1'b0, 1'b0, "step_hold");
    expect_cnt(d + 30, 32'd1, "step");
    bus.btn = 1'b1;
    tick(20);
    bus.btn = 1'b0;
    wait_until(d + 31);

    // Burst of 5.
    e = cyc;
    expect_window(e, 9, 1'b0, 1'b0, "b5_wait");
    expect_window(e + 9, 5, 1'b1, 1'b1, "burst5");
    expect_window(e + 14, 8, 1'b0, 1'b0, "b5_done");
    expect_cnt(e + 21, 32'd6, "burst5");
    applyStimulus(2'b11, 24'd0, 8'd5, 1'b0);
    tick(2);
    press_btn(4);
    wait_until(e + 22);

    // burst_len=0: the press is ignored.
    f = cyc;
    expect_window(f, 16, 1'b0, 1'b0, "burst0");
    applyStimulus(2'b11, 24'd0, 8'd0, 1'b0);
    press_btn(4);
    wait_until(f + 16);

    // Burst of 12 with a second press at strobe 8 that must be dropped.
    g = cyc;
    expect_window(g, 7, 1'b0, 1'b0, "b12_wait");
    expect_window(g + 7, 12, 1'b1, 1'b1, "burst12");
    expect_window(g + 19, 14, 1'b0, 1'b0, "b12_done");
    applyStimulus(2'b11, 24'd0, 8'd12, 1'b0);
    press_btn(4);
    wait_until(g + 8);
    press_btn(4);
    wait_until(g + 33);

    // Mode 11 -> 10 after two strobes aborts the burst.
    k = cyc;
    expect_window(k, 7, 1'b0, 1'b0, "mc_wait");
    expect_window(k + 7, 2, 1'b1, 1'b1, "mc_burst");
    expect_window(k + 9, 12, 1'b0, 1'b0, "mc_stop");
    applyStimulus(2'b11, 24'd0, 8'd5, 1'b0);
    press_btn(4);
    wait_until(k + 8);
    applyStimulus(2'b10, 24'd0, 8'd5, 1'b0);
    wait_until(k + 21);

    // Async reset in the middle of a burst clears everything at once.
    m = cyc;
    expect_window(m, 7, 1'b0, 1'b0, "rb_wait");
    expect_window(m + 7, 2, 1'b1, 1'b1, "rb_burst");
    expect_cnt(m + 8, 32'd21, "rb_burst");
    expect_window(m + 9, 17, 1'b0, 1'b0, "rb_reset");
    expect_cnt(m + 9, 32'd0, "rb_reset");
    expect_cnt(m + 25, 32'd0, "rb_after");
    applyStimulus(2'b11, 24'd0, 8'd5, 1'b0);
    press_btn(4);
    wait_until(m + 9);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    wait_until(m + 26);

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    if (exp_q.size() > 0) begin
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      n_total += exp_q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
